// File: rtl/pbd_ser_pkg.sv
// pbd_ser_pkg: FSM state encoding and counter-width helper for pbd_serializer.
package pbd_ser_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pbd_gap_counter.sv
// pbd_gap_counter: loadable down-counter with zero flag that times the idle slots between bits.
module pbd_gap_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pbd_serializer.sv
// pbd_serializer: LSB-first serializer feeding a PBD decoder (a = bit, e = strobe).
// Define PBD_SER_PARITY_EN to append an even-parity bit to every frame.
module pbd_serializer
  import pbd_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             e,
  output logic             busy,
  output logic             done
);
`ifdef PBD_SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BC_W = cnt_w(NBITS);
  localparam int GAP_W = cnt_w(GAP);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(NBITS - 1);
  localparam logic [BC_W-1:0] END_BIT = BC_W'(NBITS);
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  state_t           r_state, w_next;
  logic [NBITS-1:0] r_sr, w_load_word;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             w_accept, w_gap_zero, w_end;
`ifdef PBD_SER_PARITY_EN
  assign w_load_word = {^in_data, in_data};
`else
  assign w_load_word = in_data;
`endif
  assign w_accept = (r_state == ST_IDLE) && in_valid;
  // bit counter has already advanced past the last bit once the final gap runs
  assign w_end = (GAP == 0) ? (r_state == ST_SHIFT && r_bit_cnt == LAST_BIT)
                            : (r_state == ST_GAP && w_gap_zero && r_bit_cnt == END_BIT);
  pbd_gap_counter #(.W(GAP_W)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ST_SHIFT),
    .i_val  (GAP_LD),
    .i_dec  (r_state == ST_GAP),
    .o_zero (w_gap_zero)
  );
  always_comb begin
    w_next = r_state;
    w_next = w_end ? ST_IDLE
           : w_accept ? ST_SHIFT
           : (r_state == ST_SHIFT) ? ((GAP == 0) ? ST_SHIFT : ST_GAP)
           : (r_state == ST_GAP && w_gap_zero) ? ST_SHIFT
           : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sr      <= w_load_word;
        r_bit_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_sr      <= r_sr >> 1;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end
  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign e        = (r_state == ST_SHIFT);
  assign a        = (r_state == ST_SHIFT) && r_sr[0];
  assign done     = w_end;
endmodule

// File: tb/tb_pbd_serializer.sv
// tb_pbd_serializer: random and directed frames against a cycle-offset reference model (GAP=1 and GAP=0).
module tb_pbd_serializer;
  localparam int W = 8;
`ifdef PBD_SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [W-1:0] in_data;
  logic [1:0] rdy, bsy, ee, aa, dn;
  int n_chk = 0, n_fail = 0;
  int off[2], gp[2], y1[2], y0[2];
  logic [W-1:0] wd[2];

  always #5 clk = ~clk;

  pbd_serializer #(.WIDTH(W), .GAP(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .a(aa[0]), .e(ee[0]), .busy(bsy[0]), .done(dn[0])
  );
  pbd_serializer #(.WIDTH(W), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .a(aa[1]), .e(ee[1]), .busy(bsy[1]), .done(dn[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [W-1:0] w, input int k);
    return (k < W) ? w[k] : ^w;
  endfunction

  function automatic int pop(input logic [W-1:0] w);
    int n = 0;
    for (int k = 0; k < NB; k++) n += int'(bit_of(w, k));
    return n;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int len;
      len = NB * (1 + gp[i]);
      if (r) off[i] = 0;
      else if (off[i] == 0 && v) begin
        off[i] = 1; wd[i] = d; y1[i] = 0; y0[i] = 0;
      end else if (off[i] == len) off[i] = 0;
      else if (off[i] > 0) off[i]++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      int len, k;
      logic strobe;
      logic [4:0] exp;
      len = NB * (1 + gp[i]);
      k = off[i] - 1;
      strobe = (off[i] > 0) && (k % (1 + gp[i]) == 0);
      exp = {off[i] == 0, off[i] > 0, strobe,
             strobe && bit_of(wd[i], k / (1 + gp[i])), off[i] == len};
      check($sformatf("gap%0d_outs{rdy,busy,e,a,done}", gp[i]),
            32'({rdy[i], bsy[i], ee[i], aa[i], dn[i]}), 32'(exp));
      y1[i] += int'(ee[i] && aa[i]);
      y0[i] += int'(ee[i] && !aa[i]);
      if (off[i] == len) begin
        check($sformatf("gap%0d_y1_count", gp[i]), 32'(y1[i]), 32'(pop(wd[i])));
        check($sformatf("gap%0d_y0_count", gp[i]), 32'(y0[i]), 32'(NB - pop(wd[i])));
      end
    end
  endtask

  initial begin
    gp[0] = 1; gp[1] = 0;
    off[0] = 0; off[1] = 0;
    wd[0] = '0; wd[1] = '0;
    y1[0] = 0; y1[1] = 0; y0[0] = 0; y0[1] = 0;
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    repeat (22) step(1'b0, '0, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    repeat (22) step(1'b0, '0, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    repeat (22) step(1'b0, '0, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    repeat (40) step(1'b1, 8'h3C, 1'b0);
    repeat (22) step(1'b0, '0, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    repeat (22) step(1'b0, '0, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (600) step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 60) == 0);
    repeat (22) step(1'b0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pbd_serializer.md
PBD_SERIALIZER -- requirements
Module: pbd_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame (2..32).
REQ-002 Parameter GAP, default 1, idle cycles inserted after every transmitted bit (0..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  WIDTH  parallel word to transmit.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 a  output  1  serial bit driven to the downstream PBD select input.
REQ-009 e  output  1  bit strobe driven to the downstream PBD enable input.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-012 Upstream feeder of the PBD decoder: each e=1 cycle presents one bit on a, so downstream y0 pulses for a 0 and y1 pulses for a 1.
REQ-013 FSM states: IDLE, SHIFT, GAP.
REQ-014 All outputs are registered; no combinational path from inputs to outputs except none.
REQ-015 IDLE: in_ready=1, busy=0, e=0, a=0, done=0.
REQ-016 A word is accepted when in_valid && in_ready in cycle T; it is loaded into a shift register, and the FSM enters SHIFT in cycle T+1.
REQ-017 SHIFT: e=1, a=current bit, LSB first; the state lasts exactly one cycle per bit.
REQ-018 After SHIFT, the FSM enters GAP for GAP cycles with e=0, a=0; when GAP=0, GAP is skipped.
REQ-019 Frame length is WIDTH*(1+GAP) cycles, spanning T+1 through T+WIDTH*(1+GAP).
REQ-020 done=1 only in the last frame cycle (last GAP cycle, or last SHIFT cycle if GAP=0); the FSM is in IDLE the following cycle.
REQ-021 in_ready=0 and busy=1 throughout SHIFT/GAP; in_valid during busy is ignored and not queued.
REQ-022 Back-to-back frames: the earliest next acceptance is the first IDLE cycle after done, so the next first e is two cycles after done.
REQ-023 The bit counter and gap counter are sized to hold WIDTH(+1) and GAP without overflow; counters shall not wrap within a frame.

Reset
REQ-024 rst=1 at a clock edge forces IDLE; next cycle: in_ready=1, busy=0, e=0, a=0, done=0, and counters and shift register are cleared.
REQ-025 Reset mid-frame aborts the frame with no done pulse and no further e strobes; rst has priority over in_valid in the same cycle.

Configuration
REQ-026 Macro PBD_SER_PARITY_EN: when defined, one even-parity bit (XOR of the WIDTH data bits) is sent as an extra SHIFT/GAP slot after the data bits; frame length becomes (WIDTH+1)*(1+GAP), and done moves to the new last cycle.
REQ-027 Without PBD_SER_PARITY_EN, no parity logic is present and the frame is exactly WIDTH bits.

Structure
REQ-028 Package pbd_ser_pkg holds the FSM state enum (IDLE, SHIFT, GAP) and the counter-width helper constants.
REQ-029 A sub-module pbd_gap_counter (loadable down-counter with zero flag) implements the GAP timing; the FSM, shift register and bit counter reside in pbd_serializer.

Verification
REQ-030 WIDTH=8, GAP=1, 0xA5 accepted at T -> e=1 at T+1,3,...,15, with a = 1,0,1,0,0,1,0,1; done at T+16; in_ready=1 at T+17.
REQ-031 WIDTH=8, GAP=0, 0xFF accepted at T -> e=1 and a=1 for T+1..T+8 continuously; done at T+8.
REQ-032 in_valid held high with 0x3C during a busy 0xA5 frame -> only 0xA5 bits are emitted; 0x3C is accepted only at the first IDLE cycle after done.
REQ-033 rst asserted at T+5 of a 0xA5 frame -> from T+6, e=0, busy=0, in_ready=1, and no done pulse occurs.
REQ-034 PBD_SER_PARITY_EN defined, WIDTH=8, GAP=1: 0x01 -> ninth strobe at T+17 with a=1, done at T+18; 0xA5 -> ninth bit a=0.
REQ-035 Downstream check: a PBD model is attached -> y1 pulse count equals the popcount of the word, y0 pulse count equals WIDTH minus that popcount, and neither output is active while e=0.
